// File: rtl/outputcond.sv
// Output conditioner: stretches single-cycle event pulses into fixed-length LED blinks,
// queueing events that arrive mid-blink. Define OUTCOND_OVERFLOW_EN to add a sticky drop flag.
module outputcond #(
  parameter int ON_CYCLES   = 4,
  parameter int OFF_CYCLES  = 2,
  parameter int QUEUE_DEPTH = 3
) (
  input  logic                               clock,
  input  logic                               resetn,
  input  logic                               pulse,
  output logic                               led,
  output logic                               busy,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   pending
`ifdef OUTCOND_OVERFLOW_EN
  ,
  output logic                               overflow
`endif
);

  localparam int MAXC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int PW   = $clog2(QUEUE_DEPTH + 1);

  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);
  localparam logic [TW-1:0] T_ONE    = TW'(1);
  localparam logic [PW-1:0] P_ONE    = PW'(1);
  localparam logic [PW-1:0] P_FULL   = PW'(QUEUE_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            led_q, led_d;
  logic            busy_q, busy_d;
  logic [PW-1:0]   pending_q, pending_d;
  logic            start;

  // A blink starts from IDLE on a pulse, or at the end of OFF whenever there is demand.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    led_d   = led_q;
    start   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pulse) begin
          start = 1'b1;
        end
      end
      ST_ON: begin
        if (timer_q == '0) begin
          state_d = ST_OFF;
          timer_d = OFF_LOAD;
          led_d   = 1'b0;
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end
      ST_OFF: begin
        if (timer_q == '0) begin
          if (pulse || (pending_q != '0)) begin
            start = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
        led_d   = 1'b0;
      end
    endcase
    if (start) begin
      state_d = ST_ON;
      timer_d = ON_LOAD;
      led_d   = 1'b1;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // A start eats a queued event first, so a same-edge pulse replaces it in the queue.
  always_comb begin
    pending_d = pending_q;
    if (start) begin
      if ((pending_q != '0) && !pulse) begin
        pending_d = pending_q - P_ONE;
      end
    end else if (pulse && (state_q != ST_IDLE) && (pending_q != P_FULL)) begin
      pending_d = pending_q + P_ONE;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      led_q     <= 1'b0;
      busy_q    <= 1'b0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      led_q     <= led_d;
      busy_q    <= busy_d;
      pending_q <= pending_d;
    end
  end

`ifdef OUTCOND_OVERFLOW_EN
  logic drop;
  logic overflow_q;

  assign drop = pulse && !start && (state_q != ST_IDLE) && (pending_q == P_FULL);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end
  end

  assign overflow = overflow_q;
`endif

  assign led     = led_q;
  assign busy    = busy_q;
  assign pending = pending_q;

endmodule
